// File: rtl/control_main_seq_pkg.sv
// Shared opcode/ALU-class encodings, MUL/DIV FSM states and the registered control bundle type
// for the ID/EX main control sequencer.
package control_main_seq_pkg;

  localparam logic [6:0] OP_R       = 7'h33;
  localparam logic [6:0] OP_I_COMP  = 7'h13;
  localparam logic [6:0] OP_I_LOAD  = 7'h03;
  localparam logic [6:0] OP_I_JALR  = 7'h67;
  localparam logic [6:0] OP_S       = 7'h23;
  localparam logic [6:0] OP_B       = 7'h63;
  localparam logic [6:0] OP_J       = 7'h6F;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_R          = 3'd0;
  localparam logic [ALU_W-1:0] ALU_I_COMP     = 3'd1;
  localparam logic [ALU_W-1:0] ALU_LOAD_STORE = 3'd2;
  localparam logic [ALU_W-1:0] ALU_BRANCH     = 3'd3;
  localparam logic [ALU_W-1:0] ALU_J          = 3'd4;
  localparam logic [ALU_W-1:0] ALU_LUI        = 3'd5;
  localparam logic [ALU_W-1:0] ALU_AUIPC      = 3'd6;
  localparam logic [ALU_W-1:0] ALU_MULDIV     = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic             reg_dst;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             reg_write;
    logic             jump;
    logic             jump_jalr;
    logic             ina_is_pc;
    logic [ALU_W-1:0] alu;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{alu: ALU_R, default: '0};

endpackage

// File: rtl/control_main_seq_dec.sv
// Combinational opcode/funct7 decoder producing the control bundle plus illegal and MUL/DIV flags.
module control_main_dec
  import control_main_seq_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       is_muldiv_o
);

  always_comb begin
    ctrl_o      = CTRL_BUBBLE;
    illegal_o   = 1'b0;
    is_muldiv_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        if (ENABLE_M && (funct7_i == FUNCT7_MULDIV)) begin
          is_muldiv_o = 1'b1;
          ctrl_o.alu  = ALU_MULDIV;
        end
      end
      OP_I_COMP: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu       = ALU_I_COMP;
      end
      OP_I_LOAD: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu        = ALU_LOAD_STORE;
      end
      OP_I_JALR: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jump_jalr = 1'b1;
        ctrl_o.ina_is_pc = 1'b1;
        ctrl_o.alu       = ALU_J;
      end
      OP_S: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu       = ALU_LOAD_STORE;
      end
      OP_B: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu    = ALU_BRANCH;
      end
      OP_J: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.ina_is_pc = 1'b1;
        ctrl_o.alu       = ALU_J;
      end
      OP_LUI: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu       = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.ina_is_pc = 1'b1;
        ctrl_o.alu       = ALU_AUIPC;
      end
      // Undecodable opcodes carry a zero bundle so they can never write state.
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_main_seq.sv
// ID/EX control register with stall/flush/bubble handling and the MUL/DIV
// latency sequencer (IDLE/BUSY/DONE with a 4-bit down-counter).
module control_main_seq
  import control_main_seq_pkg::*;
#(
  parameter int          ALUCNTRL_W = 3,
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [6:0]            opcode_i,
  input  logic [6:0]            funct7_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  output logic                  ex_RegDst_o,
  output logic                  ex_Branch_o,
  output logic                  ex_MemRead_o,
  output logic                  ex_MemWrite_o,
  output logic                  ex_MemToReg_o,
  output logic                  ex_ALUSrc_o,
  output logic                  ex_RegWrite_o,
  output logic                  ex_Jump_o,
  output logic                  ex_JumpJALR_o,
  output logic                  ex_inA_is_PC_o,
  output logic [ALUCNTRL_W-1:0] ex_ALUcntrl_o,
  output logic                  ex_MulDiv_o,
  output logic                  ex_illegal_o,
  output logic                  md_busy_o,
  output logic                  md_done_o
);

  ctrl_t     dec_ctrl;
  logic      dec_illegal;
  logic      dec_muldiv;

  ctrl_t     ctrl_q, ctrl_d;
  logic      valid_q, valid_d;
  logic      muldiv_q, muldiv_d;
  logic      illegal_q, illegal_d;
  md_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic      md_busy;

  control_main_dec #(.ENABLE_M(ENABLE_M)) u_dec (
    .opcode_i    (opcode_i),
    .funct7_i    (funct7_i),
    .ctrl_o      (dec_ctrl),
    .illegal_o   (dec_illegal),
    .is_muldiv_o (dec_muldiv)
  );

  assign md_busy = (state_q == MD_BUSY);

  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    muldiv_d  = muldiv_q;
    illegal_d = illegal_q;
    state_d   = state_q;
    cnt_d     = cnt_q;

    // The counter keeps running under stall; only DONE waits for the stall to clear.
    case (state_q)
      MD_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = MD_DONE;
      end
      MD_DONE: if (!stall_i) state_d = MD_IDLE;
      default: ;
    endcase

    if (flush_i) begin
      ctrl_d    = CTRL_BUBBLE;
      valid_d   = 1'b0;
      muldiv_d  = 1'b0;
      illegal_d = 1'b0;
      state_d   = MD_IDLE;
      cnt_d     = '0;
    end else if (stall_i || md_busy) begin
      // hold the EX bundle
    end else if (id_valid_i) begin
      ctrl_d    = dec_ctrl;
      valid_d   = 1'b1;
      muldiv_d  = dec_muldiv;
      illegal_d = dec_illegal;
      if (dec_muldiv) begin
        if (MULDIV_LAT == 1) begin
          state_d = MD_DONE;
          cnt_d   = '0;
        end else begin
          state_d = MD_BUSY;
          cnt_d   = 4'(MULDIV_LAT - 1);
        end
      end
    end else begin
      ctrl_d    = CTRL_BUBBLE;
      valid_d   = 1'b0;
      muldiv_d  = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= CTRL_BUBBLE;
      valid_q   <= 1'b0;
      muldiv_q  <= 1'b0;
      illegal_q <= 1'b0;
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      muldiv_q  <= muldiv_d;
      illegal_q <= illegal_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_RegDst_o    = ctrl_q.reg_dst;
  assign ex_Branch_o    = ctrl_q.branch;
  assign ex_MemRead_o   = ctrl_q.mem_read;
  assign ex_MemWrite_o  = ctrl_q.mem_write;
  assign ex_MemToReg_o  = ctrl_q.mem_to_reg;
  assign ex_ALUSrc_o    = ctrl_q.alu_src;
  assign ex_RegWrite_o  = ctrl_q.reg_write;
  assign ex_Jump_o      = ctrl_q.jump;
  assign ex_JumpJALR_o  = ctrl_q.jump_jalr;
  assign ex_inA_is_PC_o = ctrl_q.ina_is_pc;
  assign ex_ALUcntrl_o  = ALUCNTRL_W'(ctrl_q.alu);
  assign ex_MulDiv_o    = muldiv_q;
  assign ex_illegal_o   = illegal_q;
  assign md_busy_o      = md_busy;
  assign md_done_o      = (state_q == MD_DONE);

endmodule

// File: tb/tb_control_main_seq.sv
// Bench for control_main_seq: three instances (M on/LAT 4, M off/LAT 4, M on/LAT 1) share stimulus
// and are checked against a table-driven decode plus a cycle-count reference model.
module tb_control_main_seq;

  typedef struct {
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [15:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] opcode = '0;
  logic [6:0] funct7 = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  // {valid,RegDst,Branch,MemRead,MemWrite,MemToReg,ALUSrc,RegWrite,Jump,JumpJALR,inA_is_PC,ALU[2:0],MulDiv,illegal,busy,done}
  logic [17:0] act [3];

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl [11];
  int   lat_p [3] = '{4, 4, 1};
  bit   enm_p [3] = '{1'b1, 1'b0, 1'b1};

  logic [15:0] m_ex [3];
  int          m_busy [3];
  bit          m_done [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic v, rd, br, mr, mw, m2r, as, rw, j, jr, pc, md, il, bz, dn;
    logic [2:0] alu;
    control_main_seq #(
      .ALUCNTRL_W (3),
      .ENABLE_M   (gi != 1),
      .MULDIV_LAT (gi == 2 ? 1 : 4)
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .id_valid_i     (id_valid),
      .opcode_i       (opcode),
      .funct7_i       (funct7),
      .stall_i        (stall),
      .flush_i        (flush),
      .ex_valid_o     (v),
      .ex_RegDst_o    (rd),
      .ex_Branch_o    (br),
      .ex_MemRead_o   (mr),
      .ex_MemWrite_o  (mw),
      .ex_MemToReg_o  (m2r),
      .ex_ALUSrc_o    (as),
      .ex_RegWrite_o  (rw),
      .ex_Jump_o      (j),
      .ex_JumpJALR_o  (jr),
      .ex_inA_is_PC_o (pc),
      .ex_ALUcntrl_o  (alu),
      .ex_MulDiv_o    (md),
      .ex_illegal_o   (il),
      .md_busy_o      (bz),
      .md_done_o      (dn)
    );
    assign act[gi] = {v, rd, br, mr, mw, m2r, as, rw, j, jr, pc, alu, md, il, bz, dn};
  end

  function automatic logic [15:0] bnd(input bit rd, br, mr, mw, m2r, as, rw, j, jr, pc,
                                      input logic [2:0] alu, input bit md, il);
    return {1'b1, rd, br, mr, mw, m2r, as, rw, j, jr, pc, alu, md, il};
  endfunction

  // Entries 0..8 legal opcodes, 9 the illegal default, 10 the MUL form.
  function automatic logic [15:0] ref_decode(input logic [6:0] op, input logic [6:0] f7, input bit en_m);
    if (en_m && op == 7'h33 && f7 == 7'h01) return tbl[10].exp;
    for (int k = 0; k < 9; k++)
      if (tbl[k].op == op) return tbl[k].exp;
    return tbl[9].exp;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0;
      m_busy[i] = 0;
      m_done[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      bit held;
      logic [15:0] nx;
      if (!rst_n) begin
        m_ex[i] = '0; m_busy[i] = 0; m_done[i] = 1'b0;
      end else if (flush) begin
        m_ex[i] = '0; m_busy[i] = 0; m_done[i] = 1'b0;
      end else begin
        held = stall || (m_busy[i] > 0);
        if (m_busy[i] > 0) begin
          m_busy[i] = m_busy[i] - 1;
          if (m_busy[i] == 0) m_done[i] = 1'b1;
        end else if (m_done[i] && !stall) begin
          m_done[i] = 1'b0;
        end
        if (!held) begin
          if (id_valid) begin
            nx = ref_decode(opcode, funct7, enm_p[i]);
            m_ex[i] = nx;
            if (nx[1]) begin
              if (lat_p[i] == 1) m_done[i] = 1'b1;
              else begin
                m_busy[i] = lat_p[i] - 1;
                m_done[i] = 1'b0;
              end
            end
          end else begin
            m_ex[i] = '0;
          end
        end
      end
    end
  endfunction

  function automatic logic [17:0] exp_vec(input int i);
    return {m_ex[i], (m_busy[i] > 0), m_done[i]};
  endfunction

  task automatic chk(input string name, input logic [17:0] a, input logic [17:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7);
    id_valid = v;
    opcode   = op;
    funct7   = f7;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t %s rst_n=%b v=%b op=%h f7=%h st=%b fl=%b out0=%h out1=%h out2=%h",
             $time, tag, rst_n, id_valid, opcode, funct7, stall, flush, act[0], act[1], act[2]);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_model_u%0d", tag, i), act[i], exp_vec(i));
  endtask

  logic [1:0] seq4 [5];
  logic [1:0] seq6 [6];

  initial begin
    tbl[0]  = '{7'h33, 7'h00, bnd(1,0,0,0,0,0,1,0,0,0,3'd0,0,0)};
    tbl[1]  = '{7'h13, 7'h00, bnd(1,0,0,0,0,1,1,0,0,0,3'd1,0,0)};
    tbl[2]  = '{7'h03, 7'h00, bnd(1,0,1,0,1,1,1,0,0,0,3'd2,0,0)};
    tbl[3]  = '{7'h67, 7'h00, bnd(1,0,0,0,0,0,1,0,1,1,3'd4,0,0)};
    tbl[4]  = '{7'h23, 7'h00, bnd(0,0,0,1,0,1,0,0,0,0,3'd2,0,0)};
    tbl[5]  = '{7'h63, 7'h00, bnd(0,1,0,0,0,0,0,0,0,0,3'd3,0,0)};
    tbl[6]  = '{7'h6F, 7'h00, bnd(1,0,0,0,0,0,1,1,0,1,3'd4,0,0)};
    tbl[7]  = '{7'h37, 7'h00, bnd(1,0,0,0,0,1,1,0,0,0,3'd5,0,0)};
    tbl[8]  = '{7'h17, 7'h00, bnd(1,0,0,0,0,1,1,0,0,1,3'd6,0,0)};
    tbl[9]  = '{7'h7F, 7'h00, bnd(0,0,0,0,0,0,0,0,0,0,3'd0,0,1)};
    tbl[10] = '{7'h33, 7'h01, bnd(1,0,0,0,0,0,1,0,0,0,3'd7,1,0)};
    seq4 = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    seq6 = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_u%0d", i), act[i], 18'h0);
    rst_n = 1'b1;

    // Reset dropped mid-stream, then the first load after release.
    drive(1'b1, 7'h13, 7'h00); tick("pre");
    drive(1'b1, 7'h23, 7'h00);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("async_reset_u%0d", i), act[i], 18'h0);
    rst_n = 1'b1;
    drive(1'b1, 7'h03, 7'h00);
    #1;
    chk("before_first_load", act[0], 18'h0);
    tick("first_load");
    chk("first_load", act[0], {tbl[2].exp, 2'b00});

    // Decode sweep: 9 legal opcodes plus 7'h7F.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, tbl[k].op, tbl[k].f7);
      tick("sweep");
      chk($sformatf("sweep_op%h", tbl[k].op), act[0], {tbl[k].exp, 2'b00});
    end

    // LW held by a 3-cycle stall.
    drive(1'b1, 7'h03, 7'h00); tick("lw");
    drive(1'b1, 7'h33, 7'h00);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick("stall");
      chk("stall_hold_lw", act[0], {tbl[2].exp, 2'b00});
    end
    stall = 1'b0;
    tick("unstall");
    chk("after_stall_add", act[0], {tbl[0].exp, 2'b00});

    // MUL, latency 4: id_valid ignored while busy.
    drive(1'b1, 7'h33, 7'h01); tick("mul_load");
    chk("nm_mul_is_plain_r", act[1], {tbl[0].exp, 2'b00});
    chk("lat1_done_after_load", {16'h0, act[2][1:0]}, 18'b01);
    drive(1'b1, 7'h37, 7'h00);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) tick("mul_run");
      chk($sformatf("mul_busy_done_s%0d", s), {16'h0, act[0][1:0]}, {16'h0, seq4[s]});
      if (s < 4) chk($sformatf("mul_bundle_held_s%0d", s), {2'b00, act[0][17:2]}, {2'b00, tbl[10].exp});
    end
    chk("after_done_lui", act[0], {tbl[7].exp, 2'b00});
    drive(1'b0, 7'h00, 7'h00);
    tick("idle");

    // MUL flushed on its 2nd busy cycle.
    drive(1'b1, 7'h33, 7'h01); tick("mul2_load");
    chk("nm_never_busy", {17'h0, act[1][1]}, 18'h0);
    drive(1'b0, 7'h00, 7'h00);
    tick("mul2_busy2");
    flush = 1'b1;
    tick("flush");
    flush = 1'b0;
    chk("flush_bubble", act[0], 18'h0);
    tick("post_flush1");
    chk("flush_no_done1", {16'h0, act[0][1:0]}, 18'h0);
    tick("post_flush2");
    chk("flush_no_done2", {16'h0, act[0][1:0]}, 18'h0);

    // MUL reaching DONE under a 2-cycle stall.
    drive(1'b1, 7'h33, 7'h01); tick("mul3_load");
    drive(1'b0, 7'h00, 7'h00);
    for (int s = 0; s < 6; s++) begin
      if (s > 0) tick("mul3_run");
      chk($sformatf("done_stall_s%0d", s), {16'h0, act[0][1:0]}, {16'h0, seq6[s]});
      if (s == 0) chk("lat1_pulse_s0", {16'h0, act[2][1:0]}, 18'b01);
      if (s == 1) chk("lat1_pulse_s1", {16'h0, act[2][1:0]}, 18'b00);
      stall = (s == 2 || s == 3);
    end
    stall = 1'b0;

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 11);
      rst_n    = ($urandom_range(0, 99) != 0);
      id_valid = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      if (r < 10) opcode = tbl[r].op;
      else if (r == 10) opcode = 7'h33;
      else opcode = 7'($urandom);
      funct7 = ($urandom_range(0, 1) == 0) ? 7'h01 : 7'($urandom);
      if (!rst_n) model_reset();
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
